// File: rtl/btn_rpt_uart_fmt_pkg.sv
// Shared constants for the button-report UART formatter: ASCII codes and
// the nibble-to-hex-digit helper.
package btn_rpt_uart_fmt_pkg;

   localparam logic [7:0] CH_S  = 8'h53;
   localparam logic [7:0] CH_C  = 8'h43;
   localparam logic [7:0] CH_EQ = 8'h3D;
   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   localparam logic [3:0] LAST_IDX = 4'd14;

   // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
   function automatic logic [7:0] hex_nib(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/btn_rpt_uart_fmt_fifo.sv
// Synchronous FIFO for queued button reports; first-word fall-through read,
// simultaneous push and pop allowed while full.
module btn_rpt_fifo #(
   parameter int AW = 2,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_ena,
   output logic          full,
   output logic [DW-1:0] rd_data,
   input  logic          rd_ena,
   output logic          empty
);

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd   = rd_ena && !empty;
   assign do_wr   = wr_ena && (!full || do_rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which
   // entries are valid, and a reset-free array maps to plain flops or RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/btn_rpt_uart_fmt.sv
// Queues button reports and prints each as "S=hhhh C=hhhh\r\n" one character
// at a time over a valid/ack handshake to the UART transmitter.
module btn_rpt_uart_fmt
   import btn_rpt_uart_fmt_pkg::*;
#(
   parameter int AW           = 2,
   parameter bit FILTER_NOCHG = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] rpt_state,
   input  logic [15:0] rpt_change,
   input  logic        rpt_stb,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ack,
   output logic [7:0]  drop_cnt,
   input  logic        drop_clr,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t      state;
   logic [31:0] line;
   logic [3:0]  idx;
   logic        accept;
   logic        pop;
   logic        drop;
   logic        full;
   logic        empty;
   logic [31:0] rd_data;

   assign accept = rpt_stb && !(FILTER_NOCHG && (rpt_change == 16'h0000));
   assign pop    = (state == LOAD);
   assign drop   = accept && full && !pop;
   assign busy   = !empty || (state != IDLE);

   btn_rpt_fifo #(.AW(AW), .DW(32)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_data ({rpt_state, rpt_change}),
      .wr_ena  (accept),
      .full    (full),
      .rd_data (rd_data),
      .rd_ena  (pop),
      .empty   (empty)
   );

   function automatic logic [7:0] char_at(input logic [31:0] l, input logic [3:0] i);
      case (i)
         4'd0:    return CH_S;
         4'd1:    return CH_EQ;
         4'd2:    return hex_nib(l[31:28]);
         4'd3:    return hex_nib(l[27:24]);
         4'd4:    return hex_nib(l[23:20]);
         4'd5:    return hex_nib(l[19:16]);
         4'd6:    return CH_SP;
         4'd7:    return CH_C;
         4'd8:    return CH_EQ;
         4'd9:    return hex_nib(l[15:12]);
         4'd10:   return hex_nib(l[11:8]);
         4'd11:   return hex_nib(l[7:4]);
         4'd12:   return hex_nib(l[3:0]);
         4'd13:   return CH_CR;
         4'd14:   return CH_LF;
         default: return 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         line      <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: if (!empty) state <= LOAD;
            LOAD: begin
               line      <= rd_data;
               idx       <= '0;
               out_data  <= char_at(rd_data, 4'd0);
               out_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: if (out_ack) begin
               if (idx != LAST_IDX) begin
                  idx      <= idx + 4'd1;
                  out_data <= char_at(line, idx + 4'd1);
               end else begin
                  out_valid <= 1'b0;
                  // Nothing pops during SEND, so only a push can refill an empty queue.
                  state     <= (empty && !accept) ? IDLE : LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop_clr) begin
         drop_cnt <= drop ? 8'd1 : 8'd0;
      end else if (drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_btn_rpt_uart_fmt.sv
// Directed self-checking bench for btn_rpt_uart_fmt: table of single-report
// lines plus hand-written overflow, filter, saturation and reset sequences.
module tb_btn_rpt_uart_fmt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] rpt_state = '0;
   logic [15:0] rpt_change = '0;
   logic        rpt_stb = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ack = 1'b0;
   logic [7:0]  drop_cnt;
   logic        drop_clr = 1'b0;
   logic        busy;

   int checks = 0;
   int failures = 0;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   typedef struct {
      logic [15:0]  st;
      logic [15:0]  ch;
      int           stall;
      logic [119:0] exp_line;
   } vec_t;

   vec_t         vecs [5];
   logic [119:0] exp_q [5];
   logic [119:0] l;

   always #5 clk = ~clk;

   btn_rpt_uart_fmt #(.AW(2), .FILTER_NOCHG(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rpt_state  (rpt_state),
      .rpt_change (rpt_change),
      .rpt_stb    (rpt_stb),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ack    (out_ack),
      .drop_cnt   (drop_cnt),
      .drop_clr   (drop_clr),
      .busy       (busy)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] s, input logic [15:0] c);
      rpt_state  = s;
      rpt_change = c;
      rpt_stb    = 1'b1;
      tick();
      rpt_stb    = 1'b0;
   endtask

   // Collect n characters, acking each one cycle after it is seen valid.
   task automatic get_line(input int n, input int stall, output logic [119:0] line_out);
      logic [7:0] ch;
      int         waited;
      line_out = '0;
      for (int i = 0; i < n; i++) begin
         waited = 0;
         while (!out_valid && waited < 200) begin
            tick();
            waited++;
         end
         if (!out_valid) begin
            check("char_valid_timeout", out_valid, 1'b1);
            return;
         end
         ch = out_data;
         if (i == 0 && stall > 0) begin
            for (int s = 0; s < stall; s++) begin
               tick();
               check("stall_valid", out_valid, 1'b1);
               check("stall_data", out_data, ch);
            end
         end
         line_out = {line_out[111:0], ch};
         out_ack = 1'b1;
         tick();
         out_ack = 1'b0;
      end
   endtask

   initial begin
      vecs[0] = '{16'h0001, 16'h0001, 0,  {"S=0001 C=0001", CR, LF}};
      vecs[1] = '{16'hABCD, 16'hF00E, 10, {"S=ABCD C=F00E", CR, LF}};
      vecs[2] = '{16'h1234, 16'h5678, 0,  {"S=1234 C=5678", CR, LF}};
      vecs[3] = '{16'hFFFF, 16'h8000, 3,  {"S=FFFF C=8000", CR, LF}};
      vecs[4] = '{16'h0000, 16'h0009, 0,  {"S=0000 C=0009", CR, LF}};

      repeat (3) tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_drop_cnt", drop_cnt, 8'h00);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();

      // Single reports: latency, content, stall stability, return to idle.
      for (int v = 0; v < 5; v++) begin
         send(vecs[v].st, vecs[v].ch);
         check("lat_busy_c1", busy, 1'b1);
         check("lat_valid_c1", out_valid, 1'b0);
         tick();
         check("lat_valid_c2", out_valid, 1'b0);
         tick();
         check("lat_valid_c3", out_valid, 1'b1);
         check("lat_data_c3", out_data, 8'h53);
         get_line(15, vecs[v].stall, l);
         check("vec_line", l, vecs[v].exp_line);
         check("vec_busy_done", busy, 1'b0);
         check("vec_drop_cnt", drop_cnt, 8'h00);
      end

      // Ack while idle is ignored.
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      tick();
      check("idle_ack_valid", out_valid, 1'b0);
      check("idle_ack_busy", busy, 1'b0);

      // change == 0 is filtered silently.
      send(16'h1234, 16'h0000);
      check("filter_busy", busy, 1'b0);
      repeat (4) tick();
      check("filter_valid", out_valid, 1'b0);
      check("filter_drop", drop_cnt, 8'h00);

      // Six back-to-back reports with ack held low: 1 in flight, 4 queued, 1 dropped.
      for (int k = 1; k <= 6; k++) begin
         send({4{4'(k)}}, {12'h000, 4'(k)});
      end
      check("ovf_drop_cnt", drop_cnt, 8'd1);
      check("ovf_busy", busy, 1'b1);
      exp_q[0] = {"S=1111 C=0001", CR, LF};
      exp_q[1] = {"S=2222 C=0002", CR, LF};
      exp_q[2] = {"S=3333 C=0003", CR, LF};
      exp_q[3] = {"S=4444 C=0004", CR, LF};
      exp_q[4] = {"S=5555 C=0005", CR, LF};
      for (int k = 0; k < 5; k++) begin
         get_line(15, 0, l);
         check("ovf_line", l, exp_q[k]);
      end
      check("ovf_busy_done", busy, 1'b0);

      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      check("clr_drop_cnt", drop_cnt, 8'h00);

      // Fill the queue, then push on the same edge as the LOAD pop.
      for (int k = 6; k <= 10; k++) begin
         send({4{4'(k)}}, {12'h000, 4'(k)});
      end
      check("full_no_drop", drop_cnt, 8'h00);
      get_line(15, 0, l);
      check("full_first_line", l, {"S=6666 C=0006", CR, LF});
      check("load_gap_valid", out_valid, 1'b0);
      send(16'hBEEF, 16'hCAFE);
      check("pop_push_drop", drop_cnt, 8'h00);
      exp_q[0] = {"S=7777 C=0007", CR, LF};
      exp_q[1] = {"S=8888 C=0008", CR, LF};
      exp_q[2] = {"S=9999 C=0009", CR, LF};
      exp_q[3] = {"S=AAAA C=000A", CR, LF};
      exp_q[4] = {"S=BEEF C=CAFE", CR, LF};
      for (int k = 0; k < 5; k++) begin
         get_line(15, 0, l);
         check("pop_push_line", l, exp_q[k]);
      end
      check("pop_push_busy_done", busy, 1'b0);

      // 306 reports with ack low: 5 accepted, 301 dropped, counter saturates.
      repeat (306) send(16'h0F0F, 16'h0101);
      check("sat_drop_cnt", drop_cnt, 8'hFF);
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      check("sat_clr", drop_cnt, 8'h00);
      rpt_state  = 16'h0F0F;
      rpt_change = 16'h0101;
      rpt_stb    = 1'b1;
      drop_clr   = 1'b1;
      tick();
      rpt_stb    = 1'b0;
      drop_clr   = 1'b0;
      check("clr_and_drop", drop_cnt, 8'd1);

      #2 rst_n = 1'b0;
      #1;
      check("rst_full_valid", out_valid, 1'b0);
      check("rst_full_busy", busy, 1'b0);
      check("rst_full_drop", drop_cnt, 8'h00);
      tick();
      rst_n = 1'b1;
      tick();

      // Reset in the middle of a line, at idx 7.
      send(16'h2468, 16'h1357);
      tick();
      tick();
      get_line(7, 0, l);
      check("mid_idx7_valid", out_valid, 1'b1);
      check("mid_idx7_data", out_data, 8'h43);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("mid_no_resume_valid", out_valid, 1'b0);
      check("mid_no_resume_busy", busy, 1'b0);
      send(16'h0C0C, 16'h00FF);
      tick();
      tick();
      check("post_rst_first", out_data, 8'h53);
      get_line(15, 0, l);
      check("post_rst_line", l, {"S=0C0C C=00FF", CR, LF});
      check("post_rst_busy", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
